// File: rtl/ps2_host_tx_if.sv
// Handshake between the PS/2 master controller FSM and the host transmitter.
// The master side issues byte requests; the slave (transmitter) reports progress and errors.
interface ps2_host_tx_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BUSY;
    logic       BYTE_SENT;
    logic       SEND_ERROR;
    logic [1:0] ERROR_CODE;
    logic [2:0] RETRY_COUNT;

    modport master (
        output SEND_BYTE, BYTE_TO_SEND,
        input  BUSY, BYTE_SENT, SEND_ERROR, ERROR_CODE, RETRY_COUNT
    );

    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND,
        output BUSY, BYTE_SENT, SEND_ERROR, ERROR_CODE, RETRY_COUNT
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: request-to-send inhibit, 11-bit frame,
// device ACK check, per-state watchdog and automatic retries.
//
// state          | meaning
// S_IDLE         | lines released, waiting for SEND_BYTE
// S_INHIBIT      | PS/2 clock pulled low for INHIBIT_CYCLES
// S_REQ          | clock released, start bit (data low) driven
// S_START        | waiting for the first device clock fall
// S_DATA         | shifting byte bits out LSB first
// S_PARITY       | parity bit on the line
// S_STOP         | data released (stop bit), waiting for the ACK clock
// S_ACK          | sampling the device ACK bit
// S_RELEASE_WAIT | waiting for device to release clock and data
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES    = 2,
    parameter int SYNC_STAGES    = 2,
    parameter bit ODD_PARITY     = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CLK_PS2_IN,
    output logic         CLK_PS2_OUT_EN,
    input  logic         DATA_PS2_IN,
    output logic         DATA_PS2_OUT,
    output logic         DATA_PS2_OUT_EN,
    ps2_host_tx_if.slave host
);
    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_START, S_DATA,
        S_PARITY, S_STOP, S_ACK, S_RELEASE_WAIT
    } state_t;

    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(TMR_MAX + 1);
    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    MAX_R    = 3'(MAX_RETRIES);

    state_t                 state_q, state_d;
    logic [TW-1:0]          tmr_q;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_s, data_s, clk_prev, fall;
    logic [7:0]             byte_q, byte_d;
    logic [2:0]             idx_q, idx_d, retry_q, retry_d;
    logic [1:0]             err_q, err_d, fail_code;
    logic                   sent_q, sent_d, error_q, error_d;
    logic                   fail, waiting, parity;
    logic                   clk_en_q, clk_en_d, dat_q, dat_d, dat_en_q, dat_en_d, busy_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], CLK_PS2_IN};
            data_sync <= {data_sync[SYNC_STAGES-2:0], DATA_PS2_IN};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign fall   = clk_prev & ~clk_s;
    assign parity = (^byte_q) ^ ODD_PARITY;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        retry_d   = retry_q;
        err_d     = err_q;
        sent_d    = 1'b0;
        error_d   = 1'b0;
        fail      = 1'b0;
        fail_code = 2'd0;
        waiting   = state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_RELEASE_WAIT};

        if (waiting && tmr_q == '0) begin
            fail      = 1'b1;
            fail_code = 2'd2;
        end else begin
            case (state_q)
                S_IDLE: if (host.SEND_BYTE) begin
                    byte_d  = host.BYTE_TO_SEND;
                    retry_d = 3'd0;
                    err_d   = 2'd0;
                    state_d = S_INHIBIT;
                end
                S_INHIBIT: if (tmr_q == '0) state_d = S_REQ;
                S_REQ:     state_d = S_START;
                S_START: if (fall) begin
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end
                S_DATA: if (fall) begin
                    if (idx_q == 3'd7) state_d = S_PARITY;
                    else               idx_d   = idx_q + 3'd1;
                end
                S_PARITY: if (fall) state_d = S_STOP;
                S_STOP:   if (fall) state_d = S_ACK;
                S_ACK: begin
                    if (data_s) begin
                        fail      = 1'b1;
                        fail_code = 2'd1;
                    end else begin
                        state_d = S_RELEASE_WAIT;
                    end
                end
                S_RELEASE_WAIT: if (clk_s && data_s) begin
                    sent_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (fail) begin
            err_d = fail_code;
            if (retry_q < MAX_R) begin
                retry_d = retry_q + 3'd1;
                state_d = S_INHIBIT;
            end else begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
        end

        // Line drive is derived from the next state so the pads switch with the state register.
        clk_en_d = (state_d == S_INHIBIT);
        dat_en_d = state_d inside {S_REQ, S_START, S_DATA, S_PARITY};
        dat_d    = 1'b0;
        if (state_d == S_DATA)   dat_d = byte_d[idx_d];
        if (state_d == S_PARITY) dat_d = parity;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            idx_q    <= 3'd0;
            byte_q   <= 8'd0;
            retry_q  <= 3'd0;
            err_q    <= 2'd0;
            sent_q   <= 1'b0;
            error_q  <= 1'b0;
            clk_en_q <= 1'b0;
            dat_q    <= 1'b0;
            dat_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            retry_q  <= retry_d;
            err_q    <= err_d;
            sent_q   <= sent_d;
            error_q  <= error_d;
            clk_en_q <= clk_en_d;
            dat_q    <= dat_d;
            dat_en_q <= dat_en_d;
            busy_q   <= (state_d != S_IDLE);
            if (state_d != state_q)
                tmr_q <= (state_d == S_INHIBIT) ? INH_LOAD : TO_LOAD;
            else if (fall && state_q != S_INHIBIT)
                tmr_q <= TO_LOAD;
            else if (tmr_q != '0)
                tmr_q <= tmr_q - 1'b1;
        end
    end

    assign CLK_PS2_OUT_EN   = clk_en_q;
    assign DATA_PS2_OUT     = dat_q;
    assign DATA_PS2_OUT_EN  = dat_en_q;
    assign host.BUSY        = busy_q;
    assign host.BYTE_SENT   = sent_q;
    assign host.SEND_ERROR  = error_q;
    assign host.ERROR_CODE  = err_q;
    assign host.RETRY_COUNT = retry_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: two instances (odd and even parity) share one open-drain PS/2 bus
// driven by a behavioural device model.
module tb_ps2_host_tx;
    localparam int INH = 600;
    localparam int TO  = 1000;
    localparam int H   = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1, dev_data = 1'b1;
    logic clk_line, data_line;
    logic en_o, do_o, doe_o, en_e, do_e, doe_e;
    bit   dev_abort = 1'b0;
    int   dev_edges = 0;

    int n_vec = 0, n_bad = 0;
    int inh_run[2], inh_last[2], inh_cnt[2], sent_cnt[2], err_cnt[2];
    int both_cnt = 0;

    assign clk_line  = dev_clk & ~en_o & ~en_e;
    assign data_line = dev_data & (doe_o ? do_o : 1'b1) & (doe_e ? do_e : 1'b1);

    ps2_host_tx_if hif_o ();
    ps2_host_tx_if hif_e ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2),
                  .SYNC_STAGES(2), .ODD_PARITY(1'b1)) dut_o (
        .CLK(clk), .RESET(rst_n), .CLK_PS2_IN(clk_line), .CLK_PS2_OUT_EN(en_o),
        .DATA_PS2_IN(data_line), .DATA_PS2_OUT(do_o), .DATA_PS2_OUT_EN(doe_o), .host(hif_o));

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2),
                  .SYNC_STAGES(2), .ODD_PARITY(1'b0)) dut_e (
        .CLK(clk), .RESET(rst_n), .CLK_PS2_IN(clk_line), .CLK_PS2_OUT_EN(en_e),
        .DATA_PS2_IN(data_line), .DATA_PS2_OUT(do_e), .DATA_PS2_OUT_EN(doe_e), .host(hif_e));

    always #5 clk = ~clk;

    task automatic mon_step(input int i, input logic en, input logic s, input logic e);
        if (en === 1'b1) inh_run[i]++;
        else if (inh_run[i] > 0) begin
            inh_last[i] = inh_run[i];
            inh_cnt[i]++;
            inh_run[i] = 0;
        end
        if (s === 1'b1) sent_cnt[i]++;
        if (e === 1'b1) err_cnt[i]++;
        if (s === 1'b1 && e === 1'b1) both_cnt++;
    endtask

    always @(negedge clk) begin
        mon_step(0, en_o, hif_o.BYTE_SENT, hif_o.SEND_ERROR);
        mon_step(1, en_e, hif_e.BYTE_SENT, hif_e.SEND_ERROR);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input bit even, input logic [7:0] d);
        @(negedge clk);
        if (even) begin hif_e.BYTE_TO_SEND = d; hif_e.SEND_BYTE = 1'b1; end
        else      begin hif_o.BYTE_TO_SEND = d; hif_o.SEND_BYTE = 1'b1; end
        @(negedge clk);
        hif_o.SEND_BYTE = 1'b0;
        hif_e.SEND_BYTE = 1'b0;
    endtask

    // Device side of one host-to-device frame; samples each bit just before the clock rises.
    task automatic dev_frame(input bit ack, output logic [7:0] bits, output logic par,
                             output logic stp, output bit ok);
        int n;
        ok = 1'b1; bits = 8'hxx; par = 1'bx; stp = 1'bx;
        n = 0;
        while (clk_line !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        while (clk_line !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) ok = 1'b0;
        repeat (10) @(negedge clk);
        if (data_line !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (dev_abort) break;
            dev_clk = 1'b0;
            dev_edges++;
            repeat (H) @(negedge clk);
            if (i < 8) bits[i] = data_line;
            else if (i == 8) par = data_line;
            else if (i == 9) stp = data_line;
            dev_clk = 1'b1;
            if (i == 9 && ack) dev_data = 1'b0;
            if (i == 10) dev_data = 1'b1;
            else repeat (H) @(negedge clk);
        end
        dev_clk = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic wait_cnt_sent(input int i, input int target, output bit ok);
        int n;
        n = 0;
        while (sent_cnt[i] < target && n < 300) begin @(negedge clk); n++; end
        ok = (sent_cnt[i] >= target);
    endtask

    typedef struct {
        bit         even;
        logic [7:0] data;
        bit         nack_first;
        logic       par;
        logic [1:0] err;
        logic [2:0] retry;
        int         phases;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [7:0] b;
        logic p, s;
        bit ok;
        int idx, bs, bi, be, n;

        for (int i = 0; i < 2; i++) begin
            inh_run[i] = 0; inh_last[i] = 0; inh_cnt[i] = 0; sent_cnt[i] = 0; err_cnt[i] = 0;
        end
        hif_o.SEND_BYTE = 1'b0; hif_o.BYTE_TO_SEND = 8'h00;
        hif_e.SEND_BYTE = 1'b0; hif_e.BYTE_TO_SEND = 8'h00;

        vt[0] = '{1'b0, 8'hF4, 1'b0, 1'b0, 2'd0, 3'd0, 1};
        vt[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 2'd0, 3'd0, 1};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 3'd0, 1};
        vt[3] = '{1'b0, 8'hED, 1'b1, 1'b1, 2'd1, 3'd1, 2};
        vt[4] = '{1'b0, 8'hA5, 1'b0, 1'b1, 2'd0, 3'd0, 1};

        repeat (3) @(negedge clk);
        chk("rst_busy", hif_o.BUSY, 0);
        chk("rst_clk_en", en_o, 0);
        chk("rst_data_en", doe_o, 0);
        chk("rst_data_out", do_o, 0);
        chk("rst_err_code", hif_o.ERROR_CODE, 0);
        chk("rst_retry", hif_o.RETRY_COUNT, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            idx = vt[v].even ? 1 : 0;
            bs = sent_cnt[idx]; bi = inh_cnt[idx];
            send(vt[v].even, vt[v].data);
            if (vt[v].nack_first) begin
                dev_frame(1'b0, b, p, s, ok);
                chk("nack_frame_ok", ok, 1);
            end
            dev_frame(1'b1, b, p, s, ok);
            chk("frame_ok", ok, 1);
            chk("data_bits", b, vt[v].data);
            chk("parity_bit", p, vt[v].par);
            chk("stop_bit", s, 1);
            wait_cnt_sent(idx, bs + 1, ok);
            chk("byte_sent_seen", ok, 1);
            repeat (5) @(negedge clk);
            chk("byte_sent_pulses", sent_cnt[idx] - bs, 1);
            chk("inhibit_phases", inh_cnt[idx] - bi, vt[v].phases);
            chk("inhibit_len", inh_last[idx], INH);
            chk("err_code", vt[v].even ? hif_e.ERROR_CODE : hif_o.ERROR_CODE, vt[v].err);
            chk("retry_count", vt[v].even ? hif_e.RETRY_COUNT : hif_o.RETRY_COUNT, vt[v].retry);
            chk("busy_after", vt[v].even ? hif_e.BUSY : hif_o.BUSY, 0);
        end

        // Device never clocks: three attempts time out.
        bs = sent_cnt[0]; bi = inh_cnt[0]; be = err_cnt[0];
        send(1'b0, 8'h3C);
        n = 0;
        while (err_cnt[0] == be && n < 8000) begin @(negedge clk); n++; end
        chk("timeout_error_seen", err_cnt[0] - be, 1);
        repeat (3) @(negedge clk);
        chk("timeout_phases", inh_cnt[0] - bi, 3);
        chk("timeout_err_code", hif_o.ERROR_CODE, 2);
        chk("timeout_retry", hif_o.RETRY_COUNT, 2);
        chk("timeout_clk_en", en_o, 0);
        chk("timeout_data_en", doe_o, 0);
        chk("timeout_busy", hif_o.BUSY, 0);
        chk("timeout_no_sent", sent_cnt[0] - bs, 0);

        // Request while busy is ignored; request in the BYTE_SENT cycle is accepted.
        send(1'b0, 8'hF4);
        fork
            dev_frame(1'b1, b, p, s, ok);
            begin
                repeat (700) @(negedge clk);
                hif_o.BYTE_TO_SEND = 8'h12; hif_o.SEND_BYTE = 1'b1;
                @(negedge clk);
                hif_o.SEND_BYTE = 1'b0;
            end
        join
        chk("busy_req_frame_ok", ok, 1);
        chk("busy_req_data", b, 8'hF4);
        chk("busy_req_parity", p, 0);
        n = 0;
        while (hif_o.BYTE_SENT !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("sent_cycle_seen", hif_o.BYTE_SENT, 1);
        hif_o.BYTE_TO_SEND = 8'h12; hif_o.SEND_BYTE = 1'b1;
        @(negedge clk);
        hif_o.SEND_BYTE = 1'b0;
        chk("accept_busy", hif_o.BUSY, 1);
        chk("accept_inhibit", en_o, 1);
        bs = sent_cnt[0];
        dev_frame(1'b1, b, p, s, ok);
        chk("accept_data", b, 8'h12);
        chk("accept_parity", p, 1);
        wait_cnt_sent(0, bs + 1, ok);
        chk("accept_sent", ok, 1);

        // Asynchronous reset during bit 4, then a clean transfer.
        repeat (20) @(negedge clk);
        send(1'b0, 8'hF4);
        dev_edges = 0;
        fork
            dev_frame(1'b1, b, p, s, ok);
            begin
                n = 0;
                while (dev_edges < 5 && n < 3000) begin @(negedge clk); n++; end
                repeat (8) @(negedge clk);
                chk("pre_reset_data_en", doe_o, 1);
                #2 rst_n = 1'b0;
                dev_abort = 1'b1;
                #1;
                chk("reset_clk_en", en_o, 0);
                chk("reset_data_en", doe_o, 0);
                chk("reset_busy", hif_o.BUSY, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        dev_abort = 1'b0;
        repeat (50) @(negedge clk);
        bs = sent_cnt[0];
        send(1'b0, 8'hF4);
        dev_frame(1'b1, b, p, s, ok);
        chk("post_reset_data", b, 8'hF4);
        chk("post_reset_parity", p, 0);
        wait_cnt_sent(0, bs + 1, ok);
        chk("post_reset_sent", ok, 1);
        chk("post_reset_err", hif_o.ERROR_CODE, 0);
        chk("sent_error_exclusive", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
